// File: rtl/mem_bridge_pkg.sv
// mem_bridge_pkg: types and constants shared by the CPU-to-memory bridge.
//   ctrl_e   : cpu_ctrl access-size encodings
//   state_e  : bridge FSM states
//   size_e   : decoded access width
//   LED_ADDR / CNT_ADDR : memory-mapped IO register addresses
//   Helper functions decode the size, check alignment and build store lanes/data.
package mem_bridge_pkg;

  typedef enum logic [2:0] {
    CTRL_WORD   = 3'b000,
    CTRL_HALF_S = 3'b001,
    CTRL_HALF_U = 3'b010,
    CTRL_BYTE_S = 3'b011,
    CTRL_BYTE_U = 3'b100
  } ctrl_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SZ_WORD = 2'd0,
    SZ_HALF = 2'd1,
    SZ_BYTE = 2'd2
  } size_e;

  localparam logic [31:0] LED_ADDR = 32'hFFFF_FF00;
  localparam logic [31:0] CNT_ADDR = 32'hFFFF_FF04;

  // Undefined ctrl codes are treated as word accesses.
  function automatic size_e size_of(input logic [2:0] ctrl);
    case (ctrl)
      CTRL_HALF_S, CTRL_HALF_U: return SZ_HALF;
      CTRL_BYTE_S, CTRL_BYTE_U: return SZ_BYTE;
      default:                  return SZ_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input size_e sz, input logic [1:0] a);
    return ((sz == SZ_WORD) && (a != 2'b00)) || ((sz == SZ_HALF) && a[0]);
  endfunction

  function automatic logic [3:0] store_lanes(input size_e sz, input logic [1:0] a);
    case (sz)
      SZ_HALF: return a[1] ? 4'b1100 : 4'b0011;
      SZ_BYTE: return 4'b0001 << a;
      default: return 4'b1111;
    endcase
  endfunction

  // Sub-word store data is replicated so every enabled lane sees it.
  function automatic logic [31:0] store_data(input size_e sz, input logic [31:0] w);
    case (sz)
      SZ_HALF: return {2{w[15:0]}};
      SZ_BYTE: return {4{w[7:0]}};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] l);
    return {{8{l[3]}}, {8{l[2]}}, {8{l[1]}}, {8{l[0]}}};
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: little-endian lane select and sign/zero extension for loads.
//   word : 32-bit word read from RAM or an IO register
//   addr : byte offset within the word (cpu_addr[1:0])
//   ctrl : access size encoding (ctrl_e)
//   data : formatted, right-justified load result
module mem_load_align
  import mem_bridge_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [2:0]  ctrl,
  output logic [31:0] data
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  always_comb begin
    half_sel = addr[1] ? word[31:16] : word[15:0];
    case (addr)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    case (ctrl)
      CTRL_HALF_S: data = {{16{half_sel[15]}}, half_sel};
      CTRL_HALF_U: data = {16'h0000, half_sel};
      CTRL_BYTE_S: data = {{24{byte_sel[7]}}, byte_sel};
      CTRL_BYTE_U: data = {24'h00_0000, byte_sel};
      default:     data = word;
    endcase
  end

endmodule

// File: rtl/mem_bridge.sv
// mem_bridge: single-outstanding CPU access bridge to a synchronous RAM,
// an LED register (0xFFFF_FF00) and a read-only cycle counter (0xFFFF_FF04).
//   clk, rst          : clock, synchronous active-high reset
//   cpu_req/addr/wdata/we/ctrl : CPU access request, sampled only in IDLE
//   cpu_rdata, mio_ready       : formatted load data, one-cycle completion pulse
//   bus_err                    : sticky misaligned/unmapped flag
//   ram_addr/we/din, ram_dout  : RAM port (read data valid one cycle after address)
//   led_out                    : LED register contents
module mem_bridge
  import mem_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_we,
  input  logic [2:0]  cpu_ctrl,
  output logic [31:0] cpu_rdata,
  output logic        mio_ready,
  output logic        bus_err,
  output logic [9:0]  ram_addr,
  output logic [3:0]  ram_we,
  output logic [31:0] ram_din,
  input  logic [31:0] ram_dout,
  output logic [31:0] led_out
);

  state_e      state_q;
  logic [1:0]  addr_lo_q;
  logic        we_q;
  logic [2:0]  ctrl_q;
  logic [31:0] cpu_rdata_q;
  logic        mio_ready_q;
  logic        bus_err_q;
  logic [9:0]  ram_addr_q;
  logic [3:0]  ram_we_q;
  logic [31:0] ram_din_q;
  logic [31:0] led_q;
  logic [31:0] cnt_q;

  size_e       req_size;
  logic        req_misaligned;
  logic        is_ram;
  logic        is_led;
  logic        is_cnt;
  logic [3:0]  req_lanes;
  logic [31:0] req_din;
  logic [31:0] req_mask;
  logic [31:0] io_word;

  logic [31:0] align_word;
  logic [1:0]  align_addr;
  logic [2:0]  align_ctrl;
  logic [31:0] align_data;

  always_comb begin
    req_size       = size_of(cpu_ctrl);
    req_misaligned = is_misaligned(req_size, cpu_addr[1:0]);
    is_ram         = (cpu_addr[31:12] == '0);
    is_led         = (cpu_addr[31:2] == LED_ADDR[31:2]);
    is_cnt         = (cpu_addr[31:2] == CNT_ADDR[31:2]);
    req_lanes      = store_lanes(req_size, cpu_addr[1:0]);
    req_din        = store_data(req_size, cpu_wdata);
    req_mask       = lane_mask(req_lanes);
    io_word        = is_led ? led_q : cnt_q;
  end

  // One formatter serves both paths: IO loads format in IDLE from the live
  // request, RAM loads format in WAIT from the latched request and ram_dout.
  always_comb begin
    if (state_q == S_WAIT) begin
      align_word = ram_dout;
      align_addr = addr_lo_q;
      align_ctrl = ctrl_q;
    end else begin
      align_word = io_word;
      align_addr = cpu_addr[1:0];
      align_ctrl = cpu_ctrl;
    end
  end

  mem_load_align u_align (
    .word (align_word),
    .addr (align_addr),
    .ctrl (align_ctrl),
    .data (align_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_lo_q   <= '0;
      we_q        <= 1'b0;
      ctrl_q      <= '0;
      cpu_rdata_q <= '0;
      mio_ready_q <= 1'b0;
      bus_err_q   <= 1'b0;
      ram_addr_q  <= '0;
      ram_we_q    <= '0;
      ram_din_q   <= '0;
      led_q       <= '0;
      cnt_q       <= '0;
    end else begin
      cnt_q       <= cnt_q + 32'd1;
      mio_ready_q <= 1'b0;
      ram_we_q    <= '0;
      case (state_q)
        S_IDLE: begin
          if (cpu_req) begin
            addr_lo_q <= cpu_addr[1:0];
            we_q      <= cpu_we;
            ctrl_q    <= cpu_ctrl;
            if (req_misaligned || !(is_ram || is_led || is_cnt)) begin
              bus_err_q   <= 1'b1;
              cpu_rdata_q <= '0;
              mio_ready_q <= 1'b1;
              state_q     <= S_DONE;
            end else if (is_ram) begin
              ram_addr_q <= cpu_addr[11:2];
              if (cpu_we) begin
                ram_we_q  <= req_lanes;
                ram_din_q <= req_din;
              end
              state_q <= S_ACCESS;
            end else begin
              if (cpu_we) begin
                if (is_led) begin
                  led_q <= (led_q & ~req_mask) | (req_din & req_mask);
                end
              end else begin
                cpu_rdata_q <= align_data;
              end
              mio_ready_q <= 1'b1;
              state_q     <= S_DONE;
            end
          end
        end
        S_ACCESS: begin
          if (we_q) begin
            mio_ready_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          cpu_rdata_q <= align_data;
          mio_ready_q <= 1'b1;
          state_q     <= S_DONE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // The write strobe is registered a cycle ahead of the RAM edge that consumes
  // it, so a reset raised during ACCESS must mask it directly to abort the store.
  assign ram_we    = rst ? 4'b0000 : ram_we_q;
  assign cpu_rdata = cpu_rdata_q;
  assign mio_ready = mio_ready_q;
  assign bus_err   = bus_err_q;
  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;
  assign led_out   = led_q;

endmodule

// File: tb/tb_mem_bridge.sv
module tb_mem_bridge;

  localparam logic [2:0] C_W  = 3'b000;
  localparam logic [2:0] C_HS = 3'b001;
  localparam logic [2:0] C_HU = 3'b010;
  localparam logic [2:0] C_BS = 3'b011;
  localparam logic [2:0] C_BU = 3'b100;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_we;
  logic [2:0]  cpu_ctrl;
  logic [31:0] cpu_rdata;
  logic        mio_ready;
  logic        bus_err;
  logic [9:0]  ram_addr;
  logic [3:0]  ram_we;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;
  logic [31:0] led_out;

  mem_bridge dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_we    (cpu_we),
    .cpu_ctrl  (cpu_ctrl),
    .cpu_rdata (cpu_rdata),
    .mio_ready (mio_ready),
    .bus_err   (bus_err),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout),
    .led_out   (led_out)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: read data valid one cycle after the address.
  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (ram_we[i]) mem[ram_addr][8*i +: 8] <= ram_din[8*i +: 8];
    ram_dout <= mem[ram_addr];
  end

  int          cyc = 0;
  logic [31:0] mdl_cnt;
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    mdl_cnt <= rst ? 32'd0 : mdl_cnt + 32'd1;
  end

  typedef struct {
    int          issue;
    int          lat;
    logic        chk;
    logic [31:0] rdata;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          done_cnt = 0;
  logic [31:0] last_rdata;

  task automatic monitor();
    exp_t e;
    int   lat_obs;
    forever begin
      @(negedge clk);
      if (mio_ready === 1'b1) begin
        done_cnt++;
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL spurious_ready: mio_ready=1 at cycle %0d, required no completion", cyc);
        end else begin
          e = sb.pop_front();
          lat_obs = cyc - e.issue + 1;
          if (lat_obs !== e.lat) begin
            n_err++;
            $display("FAIL %s_latency: got %0d cycles, required %0d", e.name, lat_obs, e.lat);
          end
          if (e.chk) begin
            n_vec++;
            if (cpu_rdata !== e.rdata) begin
              n_err++;
              $display("FAIL %s_rdata: got %08h, required %08h", e.name, cpu_rdata, e.rdata);
            end
          end
          last_rdata = cpu_rdata;
        end
      end
    end
  endtask

  // Drives one request for the sampling edge and records what it must return.
  task automatic issue(input logic [31:0] a, input logic [31:0] w, input logic we,
                       input logic [2:0] c, input int lat, input logic chk,
                       input logic [31:0] exp_rd, input string nm);
    exp_t e;
    cpu_addr  = a;
    cpu_wdata = w;
    cpu_we    = we;
    cpu_ctrl  = c;
    cpu_req   = 1'b1;
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    e.issue = cyc;
    e.lat   = lat;
    e.chk   = chk;
    e.rdata = exp_rd;
    e.name  = nm;
    sb.push_back(e);
  endtask

  task automatic wait_done(input string nm);
    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
      #2;
    end
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL %s_timeout: %0d completions outstanding, required 0", nm, sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cpu_req = 1'b0;
    cpu_addr = '0;
    cpu_wdata = '0;
    cpu_we = 1'b0;
    cpu_ctrl = C_W;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({mio_ready, ram_we, bus_err} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_ctl: ready=%b we=%b err=%b, required 0", mio_ready, ram_we, bus_err);
    end
    n_vec++;
    if ({cpu_rdata, led_out, ram_din, ram_addr} !== '0) begin
      n_err++;
      $display("FAIL reset_data: rdata=%08h led=%08h din=%08h addr=%03h, required 0",
               cpu_rdata, led_out, ram_din, ram_addr);
    end
    rst = 1'b0;
    // First sampling edge after reset sees the counter at 0.
    issue(32'hFFFF_FF04, 32'h0, 1'b0, C_W, 1, 1'b1, 32'h0, "reset_counter");
    wait_done("reset_counter");
  endtask

  task automatic test_word();
    issue(32'h0000_0010, 32'hDEAD_BEEF, 1'b1, C_W, 2, 1'b0, 32'h0, "sw");
    n_vec++;
    if (ram_we !== 4'b1111 || ram_din !== 32'hDEAD_BEEF || ram_addr !== 10'd4) begin
      n_err++;
      $display("FAIL sw_port: we=%b din=%08h addr=%0d, required 1111 deadbeef 4", ram_we, ram_din, ram_addr);
    end
    @(posedge clk);
    #1;
    n_vec++;
    if (ram_we !== 4'b0000) begin
      n_err++;
      $display("FAIL sw_we_pulse: we=%b in DONE, required 0000", ram_we);
    end
    wait_done("sw");
    issue(32'h0000_0010, 32'h0, 1'b0, C_W, 3, 1'b1, 32'hDEAD_BEEF, "lw");
    wait_done("lw");
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (cpu_rdata !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL rdata_hold: got %08h in IDLE, required deadbeef", cpu_rdata);
    end
  endtask

  task automatic test_load_align();
    issue(32'h20, 32'h80FF_7F01, 1'b1, C_W, 2, 1'b0, 32'h0, "sw20");
    wait_done("sw20");
    issue(32'h23, 32'h0, 1'b0, C_BS, 3, 1'b1, 32'hFFFF_FF80, "lb23");  wait_done("lb23");
    issue(32'h21, 32'h0, 1'b0, C_BU, 3, 1'b1, 32'h0000_007F, "lbu21"); wait_done("lbu21");
    issue(32'h22, 32'h0, 1'b0, C_HS, 3, 1'b1, 32'hFFFF_80FF, "lh22");  wait_done("lh22");
    issue(32'h20, 32'h0, 1'b0, C_HU, 3, 1'b1, 32'h0000_7F01, "lhu20"); wait_done("lhu20");
    issue(32'h20, 32'h0, 1'b0, C_BS, 3, 1'b1, 32'h0000_0001, "lb20");  wait_done("lb20");
    issue(32'h20, 32'h0, 1'b0, C_HS, 3, 1'b1, 32'h0000_7F01, "lh20");  wait_done("lh20");
  endtask

  task automatic test_subword_store();
    issue(32'h30, 32'h0, 1'b1, C_W, 2, 1'b0, 32'h0, "sw30");
    wait_done("sw30");
    issue(32'h31, 32'h0000_00AA, 1'b1, C_BS, 2, 1'b0, 32'h0, "sb31");
    n_vec++;
    if (ram_we !== 4'b0010 || ram_din !== 32'hAAAA_AAAA) begin
      n_err++;
      $display("FAIL sb31_port: we=%b din=%08h, required 0010 aaaaaaaa", ram_we, ram_din);
    end
    wait_done("sb31");
    issue(32'h32, 32'h0000_1234, 1'b1, C_HS, 2, 1'b0, 32'h0, "sh32");
    n_vec++;
    if (ram_we !== 4'b1100 || ram_din !== 32'h1234_1234) begin
      n_err++;
      $display("FAIL sh32_port: we=%b din=%08h, required 1100 12341234", ram_we, ram_din);
    end
    wait_done("sh32");
    issue(32'h30, 32'h0, 1'b0, C_W, 3, 1'b1, 32'h1234_AA00, "lw30");
    wait_done("lw30");
  endtask

  task automatic test_errors();
    do_reset();
    issue(32'h10, 32'h0, 1'b0, C_W, 3, 1'b1, 32'hDEAD_BEEF, "lw_pre");
    wait_done("lw_pre");
    issue(32'h0000_0006, 32'h0, 1'b0, C_W, 1, 1'b1, 32'h0, "lw_misal");
    n_vec++;
    if (bus_err !== 1'b1 || ram_we !== 4'b0000) begin
      n_err++;
      $display("FAIL lw_misal_flags: err=%b we=%b, required 1 0000", bus_err, ram_we);
    end
    wait_done("lw_misal");
    do_reset();
    n_vec++;
    if (bus_err !== 1'b0) begin
      n_err++;
      $display("FAIL err_clear: err=%b after reset, required 0", bus_err);
    end
    issue(32'h10, 32'h0, 1'b0, C_W, 3, 1'b1, 32'hDEAD_BEEF, "lw_pre2");
    wait_done("lw_pre2");
    issue(32'h0001_0000, 32'h0, 1'b0, C_W, 1, 1'b1, 32'h0, "lw_unmap");
    n_vec++;
    if (bus_err !== 1'b1 || ram_we !== 4'b0000) begin
      n_err++;
      $display("FAIL lw_unmap_flags: err=%b we=%b, required 1 0000", bus_err, ram_we);
    end
    wait_done("lw_unmap");
    issue(32'h13, 32'h5555, 1'b1, C_HS, 1, 1'b0, 32'h0, "sh_misal");
    n_vec++;
    if (ram_we !== 4'b0000) begin
      n_err++;
      $display("FAIL sh_misal_we: we=%b, required 0000", ram_we);
    end
    wait_done("sh_misal");
    issue(32'hFFFF_FF02, 32'h1111_1111, 1'b1, C_W, 1, 1'b0, 32'h0, "sw_led_misal");
    wait_done("sw_led_misal");
    n_vec++;
    if (led_out !== 32'h0) begin
      n_err++;
      $display("FAIL led_misal: led=%08h, required 00000000", led_out);
    end
    issue(32'h10, 32'h0, 1'b0, C_W, 3, 1'b1, 32'hDEAD_BEEF, "lw_after_err");
    wait_done("lw_after_err");
    n_vec++;
    if (bus_err !== 1'b1) begin
      n_err++;
      $display("FAIL err_sticky: err=%b, required 1", bus_err);
    end
  endtask

  task automatic test_io();
    logic [31:0] exp1, exp2, r1, r2;
    do_reset();
    issue(32'hFFFF_FF00, 32'h5, 1'b1, C_W, 1, 1'b0, 32'h0, "sw_led");
    n_vec++;
    if (led_out !== 32'h5) begin
      n_err++;
      $display("FAIL led_sw: led=%08h, required 00000005", led_out);
    end
    wait_done("sw_led");
    issue(32'hFFFF_FF02, 32'hFFFF_FF7E, 1'b1, C_BS, 1, 1'b0, 32'h0, "sb_led");
    wait_done("sb_led");
    n_vec++;
    if (led_out !== 32'h007E_0005) begin
      n_err++;
      $display("FAIL led_sb: led=%08h, required 007e0005", led_out);
    end
    issue(32'hFFFF_FF00, 32'h0, 1'b0, C_W, 1, 1'b1, 32'h007E_0005, "lw_led");   wait_done("lw_led");
    issue(32'hFFFF_FF02, 32'h0, 1'b0, C_BU, 1, 1'b1, 32'h0000_007E, "lbu_led"); wait_done("lbu_led");
    issue(32'hFFFF_FF04, 32'hFFFF_FFFF, 1'b1, C_W, 1, 1'b0, 32'h0, "sw_cnt");
    wait_done("sw_cnt");
    n_vec++;
    if (bus_err !== 1'b0 || led_out !== 32'h007E_0005) begin
      n_err++;
      $display("FAIL sw_cnt_ignored: err=%b led=%08h, required 0 007e0005", bus_err, led_out);
    end
    exp1 = mdl_cnt;
    issue(32'hFFFF_FF04, 32'h0, 1'b0, C_W, 1, 1'b1, exp1, "lw_cnt1");
    wait_done("lw_cnt1");
    r1 = last_rdata;
    repeat (8) @(posedge clk);
    #1;
    exp2 = mdl_cnt;
    issue(32'hFFFF_FF04, 32'h0, 1'b0, C_W, 1, 1'b1, exp2, "lw_cnt2");
    wait_done("lw_cnt2");
    r2 = last_rdata;
    n_vec++;
    if (r2 - r1 !== 32'd10) begin
      n_err++;
      $display("FAIL cnt_delta: got %0d, required 10", r2 - r1);
    end
  endtask

  task automatic test_abort_and_hold();
    exp_t e;
    int   d0;
    issue(32'h40, 32'h0, 1'b1, C_W, 2, 1'b0, 32'h0, "sw40_clear");
    wait_done("sw40_clear");
    issue(32'h40, 32'h1111_1111, 1'b1, C_W, 2, 1'b0, 32'h0, "sw40_abort");
    void'(sb.pop_back());
    rst = 1'b1;
    #1;
    n_vec++;
    if (ram_we !== 4'b0000) begin
      n_err++;
      $display("FAIL abort_we: we=%b during reset, required 0000", ram_we);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_vec++;
    if (mio_ready !== 1'b0) begin
      n_err++;
      $display("FAIL abort_ready: ready=%b after reset, required 0", mio_ready);
    end
    issue(32'h40, 32'h0, 1'b0, C_W, 3, 1'b1, 32'h0, "lw40_after_abort");
    wait_done("lw40_after_abort");
    // Request held high through ACCESS, WAIT and DONE must complete once.
    d0 = done_cnt;
    cpu_addr = 32'h10;
    cpu_we = 1'b0;
    cpu_ctrl = C_W;
    cpu_req = 1'b1;
    @(posedge clk);
    #1;
    e.issue = cyc;
    e.lat = 3;
    e.chk = 1'b1;
    e.rdata = 32'hDEAD_BEEF;
    e.name = "lw_held";
    sb.push_back(e);
    repeat (3) @(posedge clk);
    #1;
    cpu_req = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_vec++;
    if (done_cnt - d0 !== 1) begin
      n_err++;
      $display("FAIL held_req_once: %0d completions, required 1", done_cnt - d0);
    end
    wait_done("lw_held");
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_word();
    test_load_align();
    test_subword_store();
    test_errors();
    test_io();
    test_abort_and_hold();
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule

// File: doc/mem_bridge.md
MEM_BRIDGE -- requirements
Module: mem_bridge

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port cpu_req  input  1  CPU access strobe; sampled only in IDLE.
REQ-004 SHALL have port cpu_addr  input  32  byte address.
REQ-005 SHALL have port cpu_wdata  input  32  store data, right-justified.
REQ-006 SHALL have port cpu_we  input  1  1=store, 0=load.
REQ-007 SHALL have port cpu_ctrl  input  3  access size: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned; stores use 000/001/011.
REQ-008 SHALL have port cpu_rdata  output  32  formatted load data, valid while mio_ready=1.
REQ-009 SHALL have port mio_ready  output  1  one-cycle completion pulse.
REQ-010 SHALL have port bus_err  output  1  sticky error flag for misaligned or unmapped access.
REQ-011 SHALL have port ram_addr  output  10  RAM word address, cpu_addr[11:2].
REQ-012 SHALL have port ram_we  output  4  byte-lane write enables; lane i = bits 8i+7:8i.
REQ-013 SHALL have port ram_din  output  32  lane-replicated store data.
REQ-014 SHALL have port ram_dout  input  32  RAM read data, valid one cycle after ram_addr is presented.
REQ-015 SHALL have port led_out  output  32  LED register contents.

Function
REQ-016 SHALL decode addresses: RAM when cpu_addr[31:12]=0; LED register at 0xFFFF_FF00 (R/W); cycle counter at 0xFFFF_FF04 (read-only, stores ignored); anything else unmapped.
REQ-017 SHALL run FSM states IDLE, ACCESS, WAIT, DONE; reset state IDLE.
REQ-018 SHALL in IDLE, on cpu_req=1, latch addr/wdata/we/ctrl; RAM access -> ACCESS; IO, unmapped or misaligned -> DONE.
REQ-019 SHALL in ACCESS drive ram_addr; on store assert ram_we for exactly this one cycle and go to DONE; on load go to WAIT.
REQ-020 SHALL in WAIT capture ram_dout, format it, and go to DONE.
REQ-021 SHALL in DONE assert mio_ready=1 for one cycle, then return to IDLE.
REQ-022 SHALL give latencies from the req-sampling edge to mio_ready: RAM load 3 cycles, RAM store 2, IO/error 1.
REQ-023 SHALL ignore cpu_req in every state except IDLE; no queuing.
REQ-024 SHALL treat as misaligned: halfword with addr[0]=1; word with addr[1:0]!=00.
REQ-025 SHALL on error: no RAM or LED write, cpu_rdata=0, bus_err set; bus_err clears only on rst.
REQ-026 SHALL generate store lanes: word ram_we=1111; half 0011/1100 by addr[1]; byte one-hot at addr[1:0]; ram_din replicates the half or byte across lanes.
REQ-027 SHALL format loads little-endian: select lane by addr[1:0]; sign-extend or zero-extend per cpu_ctrl.
REQ-028 SHALL apply sub-word stores to the LED register with the same lane rules; IO loads also apply REQ-027.
REQ-029 SHALL keep a free-running 32-bit cycle counter, +1 every cycle, wrapping 0xFFFF_FFFF -> 0; loads return its value at the IDLE sampling edge.
REQ-030 SHALL hold cpu_rdata stable outside DONE at its last value; ram_we=0000 outside ACCESS.

Reset
REQ-031 SHALL on rst=1 at a clock edge set state=IDLE, mio_ready=0, ram_we=0000, cpu_rdata=0, bus_err=0, led_out=0, counter=0, ram_addr=0, ram_din=0.
REQ-032 SHALL, on rst mid-operation, abort the access: no mio_ready pulse and no RAM write after that edge.
REQ-033 SHALL give rst priority over cpu_req in the same cycle.

Structure
REQ-034 SHALL place the cpu_ctrl encodings, FSM state encoding, and IO address constants in shared package mem_bridge_pkg.
REQ-035 SHALL implement load lane select and extension in combinational sub-module mem_load_align (inputs word, addr[1:0], ctrl; output 32-bit data).

Verification
REQ-036 SHALL cover: SW 0x0000_0010 data 0xDEADBEEF, then LW same -> ram_we=1111 in cycle 1, ready cycle 2; load ready cycle 3 with 0xDEADBEEF.
REQ-037 SHALL cover: RAM word 0x80FF_7F01 at 0x20; LB 0x23 -> 0xFFFF_FF80; LBU 0x21 -> 0x0000_007F; LH 0x22 -> 0xFFFF_80FF; LHU 0x20 -> 0x0000_7F01.
REQ-038 SHALL cover: SB 0x31 data 0x0000_00AA -> ram_we=0010, ram_din=0xAAAA_AAAA; SH 0x32 data 0x1234 -> ram_we=1100, ram_din=0x1234_1234.
REQ-039 SHALL cover: LW 0x0000_0006 -> ready after 1 cycle, rdata 0, bus_err=1, no ram_we; LW 0x0001_0000 -> same.
REQ-040 SHALL cover: SW 0xFFFF_FF00 data 0x5 -> led_out=5 at the DONE cycle; two LW 0xFFFF_FF04 issued 10 cycles apart -> values differ by 10.
REQ-041 SHALL cover: rst asserted in the ACCESS cycle of a store -> no ram_we, no mio_ready, state IDLE next cycle; cpu_req held high during DONE -> one completion only.
